// File: rtl/reg_file_sb_pkg.sv
// Shared widths and constants for the MIPS architectural register file.
// Register 0 is hard-wired to zero throughout the datapath.
package reg_file_sb_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 0;
   localparam int NUM_REGS = 2**ADDR_W;
endpackage

// File: rtl/reg_file_sb_busy.sv
// Load-use scoreboard: one pending bit per register, raises stall on a used busy source.
// Stall is combinational from current bits and this cycle's writeback; updates on the rising edge.
module reg_file_sb_busy #(
   parameter int ADDR_W = reg_file_sb_pkg::ADDR_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic              rs_used,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic              rt_used,
   output logic              stall
);
   import reg_file_sb_pkg::*;

   localparam int NREG = 2**ADDR_W;

   logic [NREG-1:0] busy_q, busy_d;
   logic            haz_a, haz_b;

   // Set is applied after clear so a newer load keeps ownership over a same-cycle writeback.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (wr_en)    busy_d[wr_addr]   = 1'b0;
         if (busy_set) busy_d[busy_addr] = 1'b1;
      end
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   always_comb begin
      haz_a = rs_used && (rs_addr != ADDR_W'(ZERO_REG)) && busy_q[rs_addr]
              && !(BYPASS && wr_en && (wr_addr == rs_addr));
      haz_b = rt_used && (rt_addr != ADDR_W'(ZERO_REG)) && busy_q[rt_addr]
              && !(BYPASS && wr_en && (wr_addr == rt_addr));
      stall = haz_a | haz_b;
   end
endmodule

// File: rtl/reg_file_sb.sv
// 32x32 register file, two combinational read ports with optional writeback forwarding,
// one write port, debug read port and a load-use busy scoreboard driving stall.
module reg_file_sb #(
   parameter int DATA_W = reg_file_sb_pkg::DATA_W,
   parameter int ADDR_W = reg_file_sb_pkg::ADDR_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic              rs_used,
   input  logic              rt_used,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              busy_set,
   input  logic [ADDR_W-1:0] busy_addr,
   input  logic              flush,
   output logic              stall,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   import reg_file_sb_pkg::*;

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic              wr_live;
   logic              fwd_rs, fwd_rt;

   assign wr_live = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

   // Entry 0 is never written, so plain array reads already return zero for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wr_live) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   assign fwd_rs   = BYPASS && wr_live && (wr_addr == rs_addr);
   assign fwd_rt   = BYPASS && wr_live && (wr_addr == rt_addr);
   assign rs_data  = fwd_rs ? wr_data : regs_q[rs_addr];
   assign rt_data  = fwd_rt ? wr_data : regs_q[rt_addr];
   assign dbg_data = regs_q[dbg_addr];

   reg_file_sb_busy #(
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_busy (
      .clk       (clk),
      .rst_n     (rst_n),
      .busy_set  (busy_set),
      .busy_addr (busy_addr),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rs_addr   (rs_addr),
      .rs_used   (rs_used),
      .rt_addr   (rt_addr),
      .rt_used   (rt_used),
      .stall     (stall)
   );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a forwarding instance and a non-forwarding instance share all inputs.
module tb_reg_file_sb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs_addr, rt_addr, wr_addr, busy_addr, dbg_addr;
   logic        rs_used, rt_used, wr_en, busy_set, flush;
   logic [31:0] wr_data;
   logic [31:0] rs_data_b, rt_data_b, dbg_data_b;
   logic [31:0] rs_data_n, rt_data_n, dbg_data_n;
   logic        stall_b, stall_n;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_used(rs_used), .rt_used(rt_used), .rs_data(rs_data_b), .rt_data(rt_data_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
      .busy_addr(busy_addr), .flush(flush), .stall(stall_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data_b));

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_used(rs_used), .rt_used(rt_used), .rs_data(rs_data_n), .rt_data(rt_data_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_set(busy_set),
      .busy_addr(busy_addr), .flush(flush), .stall(stall_n),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data_n));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      busy_set = 1'b0; busy_addr = '0; flush = 1'b0; dbg_addr = '0;
   endtask

   // Inputs change just after the falling edge; checks sample 1ns later.
   task automatic nxt();
      @(negedge clk);
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      rs_addr = 5'd5; rt_addr = 5'd31;
      #1;
      chk("rst_rs", rs_data_b, 32'h0);
      chk("rst_rt", rt_data_b, 32'h0);
      chk("rst_stall", {31'b0, stall_b}, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // write x5 then async reset mid-cycle
      nxt(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
      nxt(); rs_addr = 5'd5; dbg_addr = 5'd5; #1;
      chk("x5_rd", rs_data_b, 32'hA5A5A5A5);
      chk("x5_dbg", dbg_data_b, 32'hA5A5A5A5);
      #1 rst_n = 1'b0; #1;
      chk("x5_async_rst", rs_data_b, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      // register 0
      nxt(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; #1;
      chk("x0_nofwd", rs_data_b, 32'h0);
      nxt(); dbg_addr = 5'd0; #1;
      chk("x0_rd", rs_data_b, 32'h0);
      chk("x0_dbg", dbg_data_b, 32'h0);
      busy_set = 1'b1; busy_addr = 5'd0;
      nxt(); rs_used = 1'b1; #1;
      chk("x0_stall", {31'b0, stall_b}, 32'h0);

      // same-cycle write/read of x7
      nxt(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
      rs_addr = 5'd7; rt_addr = 5'd7; #1;
      chk("x7_fwd_rs", rs_data_b, 32'h12345678);
      chk("x7_fwd_rt", rt_data_b, 32'h12345678);
      chk("x7_nofwd_old", rs_data_n, 32'h0);
      nxt(); rs_addr = 5'd7; #1;
      chk("x7_nofwd_new", rs_data_n, 32'h12345678);

      // load to x9, dependent rt read
      nxt(); busy_set = 1'b1; busy_addr = 5'd9;
      for (int i = 0; i < 3; i++) begin
         nxt(); rt_used = 1'b1; rt_addr = 5'd9; #1;
         chk($sformatf("x9_stall%0d", i), {31'b0, stall_b}, 32'h1);
      end
      rt_used = 1'b0; #1;
      chk("x9_unused", {31'b0, stall_b}, 32'h0);
      nxt(); rt_used = 1'b1; rt_addr = 5'd9;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000CAFE; #1;
      chk("x9_wr_stall", {31'b0, stall_b}, 32'h0);
      chk("x9_wr_rt", rt_data_b, 32'h0000CAFE);
      chk("x9_wr_stall_nb", {31'b0, stall_n}, 32'h1);
      nxt(); rt_used = 1'b1; rt_addr = 5'd9; #1;
      chk("x9_clear", {31'b0, stall_b}, 32'h0);
      chk("x9_clear_nb", {31'b0, stall_n}, 32'h0);
      chk("x9_rd_nb", rt_data_n, 32'h0000CAFE);

      // set beats same-edge write on x4
      nxt(); busy_set = 1'b1; busy_addr = 5'd4;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
      nxt(); rs_used = 1'b1; rs_addr = 5'd4; dbg_addr = 5'd4; #1;
      chk("x4_dbg", dbg_data_b, 32'h11);
      chk("x4_stall", {31'b0, stall_b}, 32'h1);
      nxt(); rs_used = 1'b1; rs_addr = 5'd4; #1;
      chk("x4_stall_hold", {31'b0, stall_b}, 32'h1);
      nxt(); rs_used = 1'b1; rs_addr = 5'd4;
      wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h22; #1;
      chk("x4_wr_stall", {31'b0, stall_b}, 32'h0);
      chk("x4_wr_rs", rs_data_b, 32'h22);
      nxt(); rs_used = 1'b1; rs_addr = 5'd4; #1;
      chk("x4_clear", {31'b0, stall_b}, 32'h0);

      // dual hazard, repeated set, flush with dropped set
      nxt(); busy_set = 1'b1; busy_addr = 5'd3;
      nxt(); busy_set = 1'b1; busy_addr = 5'd6;
      nxt(); busy_set = 1'b1; busy_addr = 5'd6;
      rs_used = 1'b1; rs_addr = 5'd3; rt_used = 1'b1; rt_addr = 5'd6; #1;
      chk("dual_stall", {31'b0, stall_b}, 32'h1);
      nxt(); rs_used = 1'b1; rs_addr = 5'd3; rt_used = 1'b1; rt_addr = 5'd6;
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; #1;
      chk("dual_half_wr", {31'b0, stall_b}, 32'h1);
      nxt(); rs_used = 1'b1; rs_addr = 5'd3; rt_used = 1'b1; rt_addr = 5'd6; #1;
      chk("dual_rt_left", {31'b0, stall_b}, 32'h1);
      rt_used = 1'b0; #1;
      chk("dual_rs_clear", {31'b0, stall_b}, 32'h0);
      rt_used = 1'b1;
      busy_set = 1'b1; busy_addr = 5'd3;
      nxt(); flush = 1'b1; busy_set = 1'b1; busy_addr = 5'd8;
      rs_used = 1'b1; rs_addr = 5'd3; rt_used = 1'b1; rt_addr = 5'd6; #1;
      chk("flush_cycle", {31'b0, stall_b}, 32'h1);
      nxt(); rs_used = 1'b1; rs_addr = 5'd3; rt_used = 1'b1; rt_addr = 5'd6; #1;
      chk("flush_after", {31'b0, stall_b}, 32'h0);
      rs_addr = 5'd8; rt_used = 1'b0; #1;
      chk("flush_x8", {31'b0, stall_b}, 32'h0);
      chk("x3_data", rs_data_n, 32'h0);
      rs_addr = 5'd3; #1;
      chk("x3_data_wr", rs_data_n, 32'h33);

      nxt();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
